// File: rtl/ecc_scrub_ctrl.sv
// ECC scrubber: walks [addr_base, addr_limit], SECDED(72,64)-checks each word and writes back corrections.
// Defining ECC_SCRUB_ERRLOG_EN adds a sticky first-error log (err_addr, err_syndrome, err_valid).

module ecc_secded (
  input  logic [63:0] data_in,
  input  logic [7:0]  ecc_in,
  output logic [63:0] data_out,
  output logic [7:0]  ecc_out,
  output logic [7:0]  syndrome
);

  // Data bits occupy the non-power-of-two positions 3..71; ecc[6:0] sit at 1,2,4..64, ecc[7] is overall parity.
  function automatic logic [6:0] pos_xor(input logic [63:0] d);
    logic [6:0] h;
    logic [5:0] k;
    h = '0;
    k = '0;
    for (int p = 3; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) h = h ^ p[6:0];
        k = k + 6'd1;
      end
    end
    return h;
  endfunction

  function automatic logic [7:0] encode(input logic [63:0] d);
    logic [6:0] h;
    h = pos_xor(d);
    return {^{d, h}, h};
  endfunction

  logic [7:0] syn_raw;
  logic [5:0] k;

  assign syn_raw = {^{data_in, ecc_in}, pos_xor(data_in) ^ ecc_in[6:0]};

  // Unknown input bits must never be reported as an error.
  assign syndrome = $isunknown({data_in, ecc_in}) ? 8'd0 : syn_raw;

  always_comb begin
    data_out = data_in;
    k        = '0;
    for (int p = 3; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (syndrome[7] && (syndrome[6:0] == p[6:0])) data_out[k] = ~data_in[k];
        k = k + 6'd1;
      end
    end
  end

  assign ecc_out = encode(data_out);

endmodule

module ecc_scrub_ctrl #(
  parameter int ADDR_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] addr_base,
  input  logic [ADDR_WIDTH-1:0] addr_limit,
  input  logic [CNT_WIDTH-1:0]  interval,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_gnt,
  input  logic                  rd_valid,
  input  logic [63:0]           rd_data,
  input  logic [7:0]            rd_ecc,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [63:0]           wr_data,
  output logic [7:0]            wr_ecc,
  input  logic                  wr_gnt,
  output logic [CNT_WIDTH-1:0]  sbe_cnt,
  output logic [CNT_WIDTH-1:0]  dbe_cnt,
  output logic                  dbe_irq,
  output logic                  pass_done,
  output logic                  busy
`ifdef ECC_SCRUB_ERRLOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [7:0]            err_syndrome,
  output logic                  err_valid
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CHECK,
    ST_WR_REQ,
    ST_NEXT
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t                state;
  logic [CNT_WIDTH-1:0]  wait_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_init;
  logic [63:0]           word_p0;
  logic [7:0]            ecc_p0;
  logic [63:0]           dec_data;
  logic [7:0]            dec_ecc;
  logic [7:0]            dec_syn;
  logic                  dec_sbe;
  logic                  dec_dbe;

  assign rd_addr = addr;
  assign wr_addr = addr;
  assign busy    = (state != ST_IDLE);

  // Capture stage: read return latched only while a read is outstanding.
  always_ff @(posedge clk) begin
    if (state == ST_RD_WAIT && rd_valid) begin
      word_p0 <= rd_data;
      ecc_p0  <= rd_ecc;
    end
  end

  ecc_secded u_dec (
    .data_in  (word_p0),
    .ecc_in   (ecc_p0),
    .data_out (dec_data),
    .ecc_out  (dec_ecc),
    .syndrome (dec_syn)
  );

  // Odd overall parity with a syndrome inside the codeword is correctable; any other nonzero syndrome is not.
  assign dec_sbe = dec_syn[7] && (dec_syn[6:0] <= 7'd71);
  assign dec_dbe = (dec_syn != 8'd0) && !dec_sbe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      addr      <= '0;
      addr_init <= 1'b1;
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      wr_data   <= '0;
      wr_ecc    <= '0;
      sbe_cnt   <= '0;
      dbe_cnt   <= '0;
      dbe_irq   <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      dbe_irq   <= 1'b0;
      pass_done <= 1'b0;
      if (addr_init) begin
        addr      <= addr_base;
        addr_init <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (enable) begin
            wait_cnt <= interval;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (wait_cnt == '0) begin
            rd_req <= 1'b1;
            state  <= ST_RD_REQ;
          end else begin
            wait_cnt <= wait_cnt - CNT_WIDTH'(1);
          end
        end
        ST_RD_REQ: begin
          if (rd_gnt) begin
            rd_req <= 1'b0;
            state  <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (rd_valid) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (dec_sbe) begin
            sbe_cnt <= sat_inc(sbe_cnt);
            wr_data <= dec_data;
            wr_ecc  <= dec_ecc;
            wr_req  <= 1'b1;
            state   <= ST_WR_REQ;
          end else if (dec_dbe) begin
            dbe_cnt <= sat_inc(dbe_cnt);
            dbe_irq <= 1'b1;
            state   <= ST_NEXT;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_WR_REQ: begin
          if (wr_gnt) begin
            wr_req <= 1'b0;
            state  <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (addr < addr_limit) begin
            addr <= addr + ADDR_WIDTH'(1);
          end else begin
            addr      <= addr_base;
            pass_done <= 1'b1;
          end
          if (enable) begin
            wait_cnt <= interval;
            state    <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ECC_SCRUB_ERRLOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr     <= '0;
      err_syndrome <= '0;
      err_valid    <= 1'b0;
    end else if (state == ST_CHECK && (dec_sbe || dec_dbe) && !err_valid) begin
      err_addr     <= addr;
      err_syndrome <= dec_syn;
      err_valid    <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Bench for ecc_scrub_ctrl: acts as the memory, injects bit flips and checks against a word-level model.

module tb_ecc_scrub_ctrl;

  localparam int AW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [AW-1:0] addr_base;
  logic [AW-1:0] addr_limit;
  logic [CW-1:0] interval;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [63:0]   rd_data;
  logic [7:0]    rd_ecc;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [7:0]    wr_ecc;
  logic          wr_gnt;
  logic [CW-1:0] sbe_cnt;
  logic [CW-1:0] dbe_cnt;
  logic          dbe_irq;
  logic          pass_done;
  logic          busy;
`ifdef ECC_SCRUB_ERRLOG_EN
  logic [AW-1:0] err_addr;
  logic [7:0]    err_syndrome;
  logic          err_valid;
`endif

  always #5 clk = ~clk;

  ecc_scrub_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .addr_base(addr_base), .addr_limit(addr_limit), .interval(interval),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ecc(rd_ecc),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ecc(wr_ecc), .wr_gnt(wr_gnt),
    .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .dbe_irq(dbe_irq), .pass_done(pass_done), .busy(busy)
`ifdef ECC_SCRUB_ERRLOG_EN
    , .err_addr(err_addr), .err_syndrome(err_syndrome), .err_valid(err_valid)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] mem     [4];
  logic [7:0]  mem_ecc [4];
  int          cur_addr;
  int          base_q;
  int          limit_q;
  int          exp_sbe;
  int          exp_dbe;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Check bit i is the parity of every data bit whose codeword position has bit i set.
  function automatic logic [7:0] ref_ecc(input logic [63:0] d);
    logic [6:0][63:0] m;
    logic [7:0]       e;
    int               j;
    m = '0;
    j = 0;
    for (int p = 3; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int i = 0; i < 7; i++) m[i[2:0]][j[5:0]] = p[i[4:0]];
        j++;
      end
    end
    e = '0;
    for (int i = 0; i < 7; i++) e[i[2:0]] = ^(d & m[i[2:0]]);
    e[7] = ^{d, e[6:0]};
    return e;
  endfunction

  function automatic logic [71:0] rand_flip(input int n);
    logic [71:0] f;
    int          a;
    int          b;
    f = '0;
    a = $urandom_range(0, 71);
    b = a;
    while (b == a) b = $urandom_range(0, 71);
    if (n >= 1) f[a[6:0]] = 1'b1;
    if (n >= 2) f[b[6:0]] = 1'b1;
    return f;
  endfunction

  task automatic do_txn(input logic [71:0] flip, input int gnt_dly, input int drop_at,
                        input int exp_wait, input int wr_dly, input bit rst_in_wr);
    int            n;
    int            nf;
    logic [1:0]    ix;
    logic [AW-1:0] a;
    ix = cur_addr[1:0];
    a  = AW'(cur_addr);
    n  = 0;
    while (rd_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rd_req_seen", 64'(rd_req), 64'(1));
    if (rd_req !== 1'b1) return;
    if (exp_wait >= 0) chk("wait_cycles", 64'(n), 64'(exp_wait));
    chk("rd_addr", 64'(rd_addr), 64'(a));
    for (int i = 0; i < gnt_dly; i++) begin
      if (i == drop_at) enable = 1'b0;
      @(negedge clk);
      chk("rd_req_hold", 64'(rd_req), 64'(1));
      chk("rd_addr_hold", 64'(rd_addr), 64'(a));
    end
    rd_gnt = 1'b1;
    @(negedge clk);
    rd_gnt = 1'b0;
    chk("rd_req_drop", 64'(rd_req), 64'(0));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rd_valid = 1'b1;
    rd_data  = mem[ix] ^ flip[63:0];
    rd_ecc   = mem_ecc[ix] ^ flip[71:64];
    @(negedge clk);
    rd_valid = 1'b0;
    rd_data  = {$urandom, $urandom};
    rd_ecc   = 8'($urandom);
    @(negedge clk);
    nf = $countones(flip);
    if (nf == 1 && exp_sbe < CMAX) exp_sbe++;
    if (nf == 2 && exp_dbe < CMAX) exp_dbe++;
    chk("sbe_cnt", 64'(sbe_cnt), 64'(exp_sbe));
    chk("dbe_cnt", 64'(dbe_cnt), 64'(exp_dbe));
    chk("dbe_irq", 64'(dbe_irq), 64'(nf == 2));
    chk("wr_req", 64'(wr_req), 64'(nf == 1));
    if (nf == 1) begin
      chk("wr_addr", 64'(wr_addr), 64'(a));
      chk("wr_data", wr_data, mem[ix]);
      chk("wr_ecc", 64'(wr_ecc), 64'(mem_ecc[ix]));
      if (rst_in_wr) begin
        #2;
        rst = 1'b1;
        #1;
        chk("rst_wr_req", 64'(wr_req), 64'(0));
        chk("rst_rd_req", 64'(rd_req), 64'(0));
        chk("rst_sbe", 64'(sbe_cnt), 64'(0));
        chk("rst_dbe", 64'(dbe_cnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_wr_data", wr_data, 64'(0));
        chk("rst_wr_ecc", 64'(wr_ecc), 64'(0));
        return;
      end
      for (int i = 0; i < wr_dly; i++) begin
        @(negedge clk);
        chk("wr_req_hold", 64'(wr_req), 64'(1));
        chk("wr_data_hold", wr_data, mem[ix]);
      end
      wr_gnt = 1'b1;
      @(negedge clk);
      wr_gnt = 1'b0;
      chk("wr_req_drop", 64'(wr_req), 64'(0));
    end
    @(negedge clk);
    chk("pass_done", 64'(pass_done), 64'(cur_addr == limit_q));
    chk("dbe_irq_one", 64'(dbe_irq), 64'(0));
    cur_addr = (cur_addr == limit_q) ? base_q : cur_addr + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; rd_gnt = 1'b0; rd_valid = 1'b0; wr_gnt = 1'b0;
    rd_data = '0; rd_ecc = '0; addr_base = '0; addr_limit = AW'(3); interval = CW'(2);
    for (int i = 0; i < 4; i++) begin
      mem[i[1:0]]     = {$urandom, $urandom};
      mem_ecc[i[1:0]] = ref_ecc(mem[i[1:0]]);
    end
    repeat (3) @(negedge clk);
    chk("reset_rd_req", 64'(rd_req), 64'(0));
    chk("reset_wr_req", 64'(wr_req), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_sbe", 64'(sbe_cnt), 64'(0));
    chk("reset_dbe", 64'(dbe_cnt), 64'(0));
    chk("reset_irq", 64'(dbe_irq), 64'(0));
    chk("reset_pass", 64'(pass_done), 64'(0));
    chk("reset_wr_data", wr_data, 64'(0));
    chk("reset_wr_ecc", 64'(wr_ecc), 64'(0));

    base_q = 0; limit_q = 3; cur_addr = 0; exp_sbe = 0; exp_dbe = 0;
    rst = 1'b0;
    enable = 1'b1;
    do_txn(72'd0, 0, -1, -1, 0, 1'b0);
    for (int i = 0; i < 4; i++) do_txn(72'd0, 0, -1, 3, 0, 1'b0);

    do_txn(72'd0, 0, -1, 3, 0, 1'b0);
    do_txn(72'd1 << 5, 0, -1, 3, 2, 1'b0);
    do_txn(72'd0, 0, -1, 3, 0, 1'b0);
    do_txn(72'd0, 0, -1, 3, 0, 1'b0);
    do_txn((72'd1 << 0) | (72'd1 << 9), 0, -1, 3, 0, 1'b0);

    interval = CW'(0);
    do_txn(72'd0, 0, -1, -1, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      do_txn(rand_flip($urandom_range(0, 2)), $urandom_range(0, 3), -1, 1, $urandom_range(0, 2), 1'b0);

    while (exp_sbe < CMAX - 1) do_txn(rand_flip(1), 0, -1, 1, 0, 1'b0);
    do_txn(rand_flip(1), 0, -1, 1, 1, 1'b0);
    do_txn(rand_flip(1), 0, -1, 1, 0, 1'b0);
    chk("sbe_saturated", 64'(sbe_cnt), 64'(CMAX));

    do_txn(72'd0, 10, 3, 1, 0, 1'b0);
    chk("drop_idle_busy", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);
    chk("drop_idle_rd_req", 64'(rd_req), 64'(0));
    chk("drop_idle_busy2", 64'(busy), 64'(0));
    enable = 1'b1;
    do_txn(72'd0, 0, -1, 2, 0, 1'b0);

    enable = 1'b0;
    @(negedge clk);
    chk("wait_drop_busy", 64'(busy), 64'(0));
    enable = 1'b1;
    do_txn(72'd0, 0, -1, 2, 0, 1'b0);

    do_txn(rand_flip(1), 0, -1, 1, 0, 1'b1);
    addr_base = AW'(1);
    base_q = 1; cur_addr = 1; exp_sbe = 0; exp_dbe = 0;
    @(negedge clk);
    chk("rst_pass_done", 64'(pass_done), 64'(0));
    rst = 1'b0;
    do_txn(72'd0, 0, -1, 2, 0, 1'b0);
    do_txn(rand_flip(2), 0, -1, 1, 0, 1'b0);
    do_txn(72'd0, 0, -1, 1, 0, 1'b0);
    do_txn(72'd0, 0, -1, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
